// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 decode constants.
//   - major opcode values (instr[6:0])
//   - func7 values that distinguish base, alternate (SUB/SRA) and M-extension ops
//   - ECALL / EBREAK full-word encodings
//   - op field layout: op = {m_flag, alt_bit, func3}
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_IMM_OP   = 7'b0010011;
  localparam logic [6:0] OPC_REG_OP   = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam int unsigned OP_W = 5;

  // Pack the op field: bit 4 = M-extension, bit 3 = alternate (SUB/SRA/SRAI), bits 2:0 = func3.
  function automatic logic [OP_W-1:0] make_op(input logic m_flag, input logic alt_bit,
                                                input logic [2:0] func3);
    return {m_flag, alt_bit, func3};
  endfunction

endpackage

// File: rtl/id_decode.sv
// id_decode: purely combinational RV32I(+M, +FENCE/ECALL/EBREAK) field decoder.
//   i_instr          : instruction word
//   o_rs1/o_rs2/o_rd : register indices, forced to 0 when the format does not use them
//   o_imm            : sign-extended immediate (0 for REG_OP/SYSTEM/MISC_MEM)
//   o_op             : {m_flag, alt_bit, func3}
//   o_ill            : illegal encoding (including M/SYS forms disabled by parameter)
module id_decode
  import riscv_pkg::*;
#(
  parameter int unsigned EN_M   = 1,
  parameter int unsigned EN_SYS = 1
) (
  input  logic [31:0]     i_instr,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [31:0]     o_imm,
  output logic [OP_W-1:0] o_op,
  output logic            o_ill
);

  localparam logic L_EN_M   = (EN_M != 32'd0);
  localparam logic L_EN_SYS = (EN_SYS != 32'd0);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_f3_addsr;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic        w_alt;
  logic        w_m;

  assign w_opc      = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  // ADD/SUB and SRL/SRA are the only REG_OP pairs where instr[30] selects a variant.
  assign w_f3_addsr = (w_f3 == 3'b000) || (w_f3 == 3'b101);

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Per-opcode field selection and legality.
  always_comb begin
    o_rs1 = i_instr[19:15];
    o_rs2 = 5'd0;
    o_rd  = i_instr[11:7];
    o_imm = 32'd0;
    w_alt = 1'b0;
    w_m   = 1'b0;
    o_ill = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        o_rs1 = 5'd0;
        o_imm = {i_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        o_rs1 = 5'd0;
        o_imm = w_imm_j;
      end
      OPC_JALR: begin
        o_imm = w_imm_i;
        o_ill = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        o_rs2 = i_instr[24:20];
        o_rd  = 5'd0;
        o_imm = w_imm_b;
        o_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        o_imm = w_imm_i;
        o_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        o_rs2 = i_instr[24:20];
        o_rd  = 5'd0;
        o_imm = w_imm_s;
        o_ill = (w_f3 > 3'b010);
      end
      OPC_IMM_OP: begin
        o_imm = w_imm_i;
        case (w_f3)
          3'b001: o_ill = (w_f7 != F7_BASE);
          3'b101: begin
            w_alt = i_instr[30];
            o_ill = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
          end
          default: o_ill = 1'b0;
        endcase
      end
      OPC_REG_OP: begin
        o_rs2 = i_instr[24:20];
        if (w_f7 == F7_MULDIV) begin
          w_m   = L_EN_M;
          o_ill = !L_EN_M;
        end else begin
          w_alt = w_f3_addsr ? i_instr[30] : 1'b0;
          o_ill = !((w_f7 == F7_BASE) || ((w_f7 == F7_ALT) && w_f3_addsr));
        end
      end
      OPC_MISC_MEM: begin
        o_rs1 = 5'd0;
        o_rd  = 5'd0;
        o_ill = !(L_EN_SYS && (w_f3 == 3'b000));
      end
      OPC_SYSTEM: begin
        o_rs1 = 5'd0;
        o_rd  = 5'd0;
        o_ill = !(L_EN_SYS && ((i_instr == INSTR_ECALL) || (i_instr == INSTR_EBREAK)));
      end
      default: begin
        // Unknown opcode: no operands are meaningful.
        o_rs1 = 5'd0;
        o_rd  = 5'd0;
        o_ill = 1'b1;
      end
    endcase
    o_op = make_op(w_m, w_alt, w_f3);
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32 instruction-decode pipeline stage.
//   clk, reset_n           : clock, async active-low reset
//   flush                  : synchronous kill, wins over every other event
//   in_valid/in_ready      : upstream handshake carrying instr and in_pc
//   out_valid/out_ready    : downstream handshake for the registered decode bundle
//   out_pc, rs1, rs2, rd, imm, opcode, op, ill : registered decode bundle
//   ill_count              : saturating count of accepted illegal instructions
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned EN_M        = 1,
  parameter int unsigned EN_SYS      = 1,
  parameter int unsigned EN_LOAD_USE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      imm,
  output logic [6:0]       opcode,
  output logic [OP_W-1:0]  op,
  output logic             ill,
  output logic [CNT_W-1:0] ill_count
);

  localparam logic L_EN_LOAD_USE = (EN_LOAD_USE != 32'd0);

  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic [31:0]      w_imm;
  logic [OP_W-1:0]  w_op;
  logic             w_ill;
  logic             w_hazard;
  logic             w_capture;

  logic             r_valid;
  logic [31:0]      r_pc;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [31:0]      r_imm;
  logic [6:0]       r_opcode;
  logic [OP_W-1:0]  r_op;
  logic             r_ill;
  logic [CNT_W-1:0] r_ill_count;

  id_decode #(
    .EN_M   (EN_M),
    .EN_SYS (EN_SYS)
  ) u_decode (
    .i_instr (instr),
    .o_rs1   (w_rs1),
    .o_rs2   (w_rs2),
    .o_rd    (w_rd),
    .o_imm   (w_imm),
    .o_op    (w_op),
    .o_ill   (w_ill)
  );

  // A load sitting in the output register cannot forward its data in time for a
  // dependent instruction; unused source fields decode to 0 and rd!=0 keeps x0 out.
  assign w_hazard = L_EN_LOAD_USE && r_valid && (r_opcode == OPC_LOAD) && (r_rd != 5'd0) &&
                    ((w_rs1 == r_rd) || (w_rs2 == r_rd));

  assign in_ready  = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_capture = in_valid && in_ready;

  // Output bundle register: flush, then capture, then drain; otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_pc     <= 32'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_rd     <= 5'd0;
      r_imm    <= 32'd0;
      r_opcode <= 7'd0;
      r_op     <= '0;
      r_ill    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_pc     <= in_pc;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rd     <= w_rd;
      r_imm    <= w_imm;
      r_opcode <= instr[6:0];
      r_op     <= w_op;
      r_ill    <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Saturating illegal-instruction counter; capture already excludes flushed inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ill_count <= '0;
    end else if (w_capture && w_ill && (r_ill_count != {CNT_W{1'b1}})) begin
      r_ill_count <= r_ill_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_ill_count <= r_ill_count;
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign imm       = r_imm;
  assign opcode    = r_opcode;
  assign op        = r_op;
  assign ill       = r_ill;
  assign ill_count = r_ill_count;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23, IMMOP = 7'h13;
  localparam logic [6:0] REGOP = 7'h33, MISC = 7'h0F, SYS = 7'h73;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  op;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: default parameters
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = 32'd0, in_pc = 32'd0;
  logic        in_ready, out_valid, ill;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd, op;
  logic [6:0]  opcode;
  logic [15:0] ill_count;

  // DUT b: M, SYS and load-use disabled, 2-bit counter
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_instr = 32'd0, b_in_pc = 32'd0;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_out_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_op;
  logic [6:0]  b_opcode;
  logic [1:0]  b_ill_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  id_stage #(.EN_M(1), .EN_SYS(1), .EN_LOAD_USE(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .opcode(opcode), .op(op),
    .ill(ill), .ill_count(ill_count));

  id_stage #(.EN_M(0), .EN_SYS(0), .EN_LOAD_USE(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .opcode(b_opcode),
    .op(b_op), .ill(b_ill), .ill_count(b_ill_count));

  // Reference decode from the ISA rules, using integer arithmetic for immediates.
  function automatic exp_t ref_dec(input logic [31:0] x, input bit en_m, input bit en_sys);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int sx;
    bit known, u1, u2, ud;
    opc = x[6:0]; f3 = x[14:12]; f7 = x[31:25]; sx = int'($signed(x));
    e = '0;
    known = opc inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMMOP, REGOP, MISC, SYS};
    u1 = known && !(opc inside {LUI, AUIPC, JAL, SYS, MISC});
    u2 = opc inside {BRANCH, STORE, REGOP};
    ud = known && !(opc inside {BRANCH, STORE, SYS, MISC});
    e.rs1 = u1 ? x[19:15] : 5'd0;
    e.rs2 = u2 ? x[24:20] : 5'd0;
    e.rd  = ud ? x[11:7]  : 5'd0;
    if (opc inside {LUI, AUIPC}) e.imm = x & 32'hFFFF_F000;
    else if (opc == JAL)
      e.imm = 32'((sx >>> 31) * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2);
    else if (opc == BRANCH)
      e.imm = 32'((sx >>> 31) * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2);
    else if (opc == STORE) e.imm = 32'((sx >>> 25) * 32 + int'(x[11:7]));
    else if (opc inside {JALR, LOAD, IMMOP}) e.imm = 32'(sx >>> 20);
    else e.imm = 32'd0;
    e.op[2:0] = f3;
    if ((opc == IMMOP && f3 == 3'd5) || (opc == REGOP && (f3 == 3'd0 || f3 == 3'd5) && f7 != 7'd1))
      e.op[3] = x[30];
    if (!known) e.ill = 1'b1;
    else if (opc == JALR) e.ill = (f3 != 3'd0);
    else if (opc == BRANCH) e.ill = (f3 == 3'd2 || f3 == 3'd3);
    else if (opc == LOAD) e.ill = (f3 == 3'd3 || f3 >= 3'd6);
    else if (opc == STORE) e.ill = (f3 > 3'd2);
    else if (opc == IMMOP) e.ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32);
    else if (opc == REGOP && f7 == 7'd1) begin e.ill = !en_m; e.op[4] = en_m; end
    else if (opc == REGOP) e.ill = !(f7 == 7'd0 || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)));
    else if (opc == MISC) e.ill = !(en_sys && f3 == 3'd0);
    else if (opc == SYS) e.ill = !(en_sys && (x == 32'h0000_0073 || x == 32'h0010_0073));
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] tab [12];
    logic [31:0] x;
    tab = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMMOP, REGOP, MISC, SYS, 7'h7F};
    x = $urandom;
    x[6:0]   = tab[$urandom_range(0, 11)];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'd0;
      1: x[31:25] = 7'd32;
      2: x[31:25] = 7'd1;
      default: x[31:25] = 7'($urandom);
    endcase
    if (x[6:0] == SYS && $urandom_range(0, 1) == 1) x = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h0010_0073;
    return x;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid = v; instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins);
    b_in_valid = v; b_instr = ins; b_in_pc = 32'h0; b_out_ready = 1'b1; b_flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, ill, ill_count, out_pc, rs1, rs2, rd, imm, opcode, op} !== '0) begin
      n_fail++; $display("FAIL reset_a_outputs got=%h exp=0", {out_valid, ill, ill_count, out_pc, rs1, rs2, rd, imm, opcode, op});
    end
    step(); step();
    n_tests++;
    if ({b_out_valid, b_ill, b_ill_count, b_rd, b_imm} !== '0) begin
      n_fail++; $display("FAIL reset_b_outputs got=%h exp=0", {b_out_valid, b_ill, b_ill_count, b_rd, b_imm});
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got=%b exp=1", in_ready); end
    step();
    n_tests++;
    if ({out_valid, rd, rs1, rs2, imm, opcode, ill, op, out_pc} !== {1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 7'b0010011, 1'b0, 5'd0, 32'h100}) begin
      n_fail++; $display("FAIL addi_bundle got v=%b rd=%0d rs1=%0d rs2=%0d imm=%0d opc=%b ill=%b op=%b pc=%h exp v=1 rd=1 rs1=0 rs2=0 imm=5 opc=0010011 ill=0 op=00000 pc=100",
                         out_valid, rd, rs1, rs2, imm, opcode, ill, op, out_pc);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h0000_A103, 32'h200, 1'b1, 1'b0);
    step();
    n_tests++;
    if ({out_valid, opcode, rd, rs1, imm, ill} !== {1'b1, 7'b0000011, 5'd2, 5'd1, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL lw_bundle got v=%b opc=%b rd=%0d rs1=%0d imm=%0d ill=%b exp v=1 opc=0000011 rd=2 rs1=1 imm=0 ill=0",
                         out_valid, opcode, rd, rs1, imm, ill);
    end
    drive(1'b1, 32'h0011_01B3, 32'h204, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall got=%b exp=0", in_ready); end
    step();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL loaduse_bubble got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    step();
    n_tests++;
    if ({out_valid, rs1, rs2, rd, out_pc, ill} !== {1'b1, 5'd2, 5'd1, 5'd3, 32'h204, 1'b0}) begin
      n_fail++; $display("FAIL add_after_lw got v=%b rs1=%0d rs2=%0d rd=%0d pc=%h ill=%b exp v=1 rs1=2 rs2=1 rd=3 pc=204 ill=0",
                         out_valid, rs1, rs2, rd, out_pc, ill);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_params();
    logic [31:0] seq [4];
    seq = '{32'h0220_81B3, 32'h0000_0073, 32'h0000_000F, 32'h0010_0073};
    n_tests++;
    if (b_ill_count !== 2'd0) begin n_fail++; $display("FAIL b_count_start got=%0d exp=0", b_ill_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 32'h40 + 32'(i), 1'b1, 1'b0);
      drive_b(1'b1, seq[i]);
      step();
      n_tests++;
      if ({out_valid, ill, op} !== {1'b1, 1'b0, (i == 0) ? 5'b10000 : 5'b00000}) begin
        n_fail++; $display("FAIL a_legal_%0d got v=%b ill=%b op=%b exp v=1 ill=0 op=%b", i, out_valid, ill, op, (i == 0) ? 5'b10000 : 5'b00000);
      end
      n_tests++;
      if ({b_out_valid, b_ill, b_op[4], b_ill_count} !== {1'b1, 1'b1, 1'b0, (i == 3) ? 2'd3 : 2'(i + 1)}) begin
        n_fail++; $display("FAIL b_illegal_%0d got v=%b ill=%b m=%b cnt=%0d exp v=1 ill=1 m=0 cnt=%0d", i, b_out_valid, b_ill, b_op[4], b_ill_count, (i == 3) ? 3 : i + 1);
      end
    end
    n_tests++;
    if (ill_count !== exp_cnt) begin n_fail++; $display("FAIL a_count_legal got=%0d exp=%0d", ill_count, exp_cnt); end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive_b(1'b1, 32'h0000_A103);
    step();
    drive_b(1'b1, 32'h0011_01B3);
    #1;
    n_tests++;
    if ({b_out_valid, b_opcode, b_in_ready} !== {1'b1, 7'b0000011, 1'b1}) begin
      n_fail++; $display("FAIL b_no_loaduse got v=%b opc=%b rdy=%b exp v=1 opc=0000011 rdy=1", b_out_valid, b_opcode, b_in_ready);
    end
    step();
    n_tests++;
    if ({b_out_valid, b_rs1, b_rs2, b_ill_count} !== {1'b1, 5'd2, 5'd1, 2'd3}) begin
      n_fail++; $display("FAIL b_add_b2b got v=%b rs1=%0d rs2=%0d cnt=%0d exp v=1 rs1=2 rs2=1 cnt=3", b_out_valid, b_rs1, b_rs2, b_ill_count);
    end
    drive_b(1'b0, 32'd0);
    step();
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h00A0_0113, 32'h300, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0030_8193, 32'h304, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d got=%b exp=0", i, in_ready); end
      step();
      n_tests++;
      if ({out_valid, out_pc, rd, rs1, imm} !== {1'b1, 32'h300, 5'd2, 5'd0, 32'd10}) begin
        n_fail++; $display("FAIL stall_hold_%0d got v=%b pc=%h rd=%0d rs1=%0d imm=%0d exp v=1 pc=300 rd=2 rs1=0 imm=10", i, out_valid, out_pc, rd, rs1, imm);
      end
    end
    drive(1'b1, 32'h0030_8193, 32'h304, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    step();
    n_tests++;
    if ({out_valid, out_pc, rd, rs1, imm} !== {1'b1, 32'h304, 5'd3, 5'd1, 32'd3}) begin
      n_fail++; $display("FAIL stall_next got v=%b pc=%h rd=%0d rs1=%0d imm=%0d exp v=1 pc=304 rd=3 rs1=1 imm=3", out_valid, out_pc, rd, rs1, imm);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0050_0093, 32'h400, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 32'h404, 1'b1, 1'b1);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL flush_pre got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    n_tests++;
    if ({out_valid, ill_count} !== {1'b0, exp_cnt}) begin
      n_fail++; $display("FAIL flush_kill got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, ill_count, exp_cnt);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic m_valid = 1'b0;
    exp_t m_b = '0, d;
    logic [6:0] m_opc = 7'd0;
    logic [31:0] m_pc = 32'd0, ins, pc;
    logic v, ordy, fl, haz, rdy;
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 19) == 0); ins = gen_instr(); pc = $urandom;
      drive(v, ins, pc, ordy, fl);
      #1;
      d = ref_dec(ins, 1'b1, 1'b1);
      haz = m_valid && (m_opc == LOAD) && (m_b.rd != 5'd0) && (d.rs1 == m_b.rd || d.rs2 == m_b.rd);
      rdy = (!m_valid || ordy) && !haz && !fl;
      n_tests++;
      if (in_ready !== rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d instr=%h got=%b exp=%b", c, ins, in_ready, rdy); end
      step();
      if (fl) m_valid = 1'b0;
      else if (v && rdy) begin
        m_valid = 1'b1; m_b = d; m_opc = ins[6:0]; m_pc = pc;
        if (d.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else if (ordy) m_valid = 1'b0;
      n_tests++;
      if ({out_valid, ill_count} !== {m_valid, exp_cnt}) begin
        n_fail++; $display("FAIL rnd_valid_cnt cyc=%0d got v=%b cnt=%0d exp v=%b cnt=%0d", c, out_valid, ill_count, m_valid, exp_cnt);
      end
      if (m_valid) begin
        n_tests++;
        if ({rs1, rs2, rd, imm, op, ill, opcode, out_pc} !== {m_b, m_opc, m_pc}) begin
          n_fail++; $display("FAIL rnd_bundle cyc=%0d got=%h exp=%h", c, {rs1, rs2, rd, imm, op, ill, opcode, out_pc}, {m_b, m_opc, m_pc});
        end
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hFFFF_FFFF, 32'h500, 1'b0, 1'b0);
    step();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if ({out_valid, ill, ill_count} !== {1'b1, 1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL pre_reset got v=%b ill=%b cnt=%0d exp v=1 ill=1 cnt=%0d", out_valid, ill, ill_count, exp_cnt);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, ill, ill_count, out_pc, rs1, rs2, rd, imm, opcode, op} !== '0) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=0", {out_valid, ill, ill_count, out_pc, rs1, rs2, rd, imm, opcode, op});
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    exp_cnt = 16'd0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_params();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter EN_M, default 1, SHALL enable RV32M decode (REG_OP, func7=0000001).
REQ-003 Parameter EN_SYS, default 1, SHALL enable FENCE (MISC_MEM, func3=000), ECALL (0x00000073) and EBREAK (0x00100073) as legal.
REQ-004 Parameter EN_LOAD_USE, default 1, SHALL enable load-use bubble insertion.
REQ-005 Parameter CNT_W, default 16, SHALL set the illegal-instruction counter width.
REQ-006 Ports (name, direction, width, meaning), in this order:
- clk, in, 1: clock.
- reset_n, in, 1: async active-low reset.
- flush, in, 1: sync kill of stage contents.
- in_valid, in, 1: instr/in_pc valid.
- in_ready, out, 1: stage accepts this cycle.
- instr, in, 32: fetched instruction.
- in_pc, in, 32: instruction address.
- out_valid, out, 1: decoded bundle valid.
- out_ready, in, 1: EX accepts bundle.
- out_pc, out, 32: registered in_pc.
- rs1, rs2, rd, out, 5 each: register indices, 0 when unused.
- imm, out, 32: sign-extended immediate.
- opcode, out, 7: instr[6:0].
- op, out, 5: {m_flag, alt_bit, func3}.
- ill, out, 1: illegal instruction.
- ill_count, out, CNT_W: saturating count of illegal instructions accepted.

Function
REQ-007 Decode SHALL be combinational on instr; all decoded outputs SHALL be registered, latency exactly 1 cycle from acceptance.
REQ-008 Field rules: rs1=0 for LUI/AUIPC/JAL; rs2 used only by BRANCH/STORE/REG_OP; rd=0 for BRANCH/STORE; rs1, rs2 and rd all 0 for SYSTEM and MISC_MEM; imm per RV32I U/J/B/S/I formats, 0 for REG_OP/SYSTEM/MISC_MEM.
REQ-009 op[3] SHALL equal instr[30] only for IMM_OP func3=101 or REG_OP func3 in {000,101} with func7!=0000001; otherwise 0. op[4] SHALL be 1 only for legal M instructions.
REQ-010 ill SHALL be 1 for unknown opcodes, JALR func3!=0, BRANCH func3 in {010,011}, LOAD func3 in {011,110,111}, STORE func3>010, bad IMM_OP shift func7, REG_OP func7 not in the legal set, and M/SYS encodings whose enable parameter is 0.
REQ-011 Illegal instructions SHALL still be accepted and presented with ill=1; they SHALL NOT stall the stage.
REQ-012 Handshake: in_ready = (!out_valid || out_ready) && !hazard && !flush; capture on in_valid && in_ready.
REQ-013 When out_valid && !out_ready, all outputs SHALL hold stable.
REQ-014 out_valid SHALL clear on out_ready without a capture.
REQ-015 hazard SHALL be 1 when EN_LOAD_USE=1, out_valid=1, opcode=LOAD, rd!=0, and the incoming instruction uses rs1 or rs2 equal to that rd. Exactly one empty cycle SHALL follow the load's acceptance.
REQ-016 flush SHALL win over all events: next cycle out_valid=0, the same-cycle input is dropped, and ill_count is unchanged by that input.
REQ-017 ill_count SHALL increment on each capture with ill=1 and saturate at all-ones.

Reset
REQ-018 On reset_n low, out_valid, ill, all fields, out_pc and ill_count SHALL become 0 immediately.
REQ-019 Reset mid-handshake SHALL discard the held bundle; in_ready SHALL be 1 from the first cycle after reset_n is released.

Structure
REQ-020 Opcode constants, the op field layout and the ECALL/EBREAK encodings SHALL reside in the shared package riscv_pkg.
REQ-021 Combinational decode SHALL be a sub-module id_decode; id_stage adds the register, handshake, hazard and counter logic.

Verification
REQ-022 Send 0x00500093 with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, opcode=0010011, ill=0.
REQ-023 Send 0x0000A103 then 0x001101B3 back-to-back with out_ready=1 -> LW output, then one cycle out_valid=0, then ADD with rs1=2, rs2=1.
REQ-024 Send 0x022081B3 -> with EN_M=1: op=10000, ill=0; with EN_M=0: ill=1 and ill_count goes 0->1.
REQ-025 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; on release, the next instruction appears 1 cycle later.
REQ-026 Assert flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is not emitted.
REQ-027 Pull reset_n low mid-stream -> all outputs 0 immediately, including ill_count.
